// File: rtl/dtw_mem_arb.sv
// -----------------------------------------------------------------------------
// dtw_mem_arb
//   Shares the single external 1024x32 SRAM port between three requesters:
//   port 0 = backtrace writeback, port 1 = template fetch, port 2 = host/debug.
//   One access is granted per cycle by fixed priority (0 > 1 > 2), overridden
//   by aging: a port that has waited MAX_WAIT cycles becomes urgent and the
//   lowest-index urgent port wins. A write is held off for one cycle after a
//   read grant so the data pads can turn around. Read data comes back with a
//   fixed two-cycle latency from the grant and is tagged with the port index.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i/we_i        per-port request / write enable
//   addr_i/wdata_i    per-port address / write data, port p at [p*W +: W]
//   gnt_o             one-hot (or zero) combinational grant
//   rvalid_o          per-port read-data-valid pulse, registered
//   rdata_o           shared read data (pass-through of data_i)
//   addr_o, data_o    registered SRAM address / write data
//   data_tri_ena      registered pad drive enable for data_o
//   WR_o, CS_o        registered SRAM write strobe / chip select
//   data_i            SRAM read data, valid the cycle after a read command
// -----------------------------------------------------------------------------
module dtw_mem_arb #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      req_i,
  input  logic [2:0]      we_i,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      gnt_o,
  output logic [2:0]      rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   data_o,
  output logic            data_tri_ena,
  output logic            WR_o,
  output logic            CS_o,
  input  logic [DW-1:0]   data_i
);

  localparam int              WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q [3];
  // A read granted last edge: drives both the turnaround bubble and the
  // first stage of the read-return pipeline.
  logic          rd_pend_q;
  logic [1:0]    rd_port_q;

  logic [2:0]    elig;
  logic [2:0]    urgent;
  logic [2:0]    pick;
  logic [2:0]    gnt;
  logic [1:0]    gnt_idx;
  logic          any_gnt;
  logic          gnt_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    elig    = req_i & ~(we_i & {3{rd_pend_q}});
    urgent  = '0;
    for (int p = 0; p < 3; p++) urgent[p] = (wait_q[p] == WAIT_MAX);
    // Urgent eligible ports shadow the plain priority order entirely.
    pick    = ((elig & urgent) != 3'b000) ? (elig & urgent) : elig;
    gnt     = 3'b000;
    gnt_idx = 2'd0;
    if (!rst_i) begin
      if (pick[0]) begin
        gnt     = 3'b001;
        gnt_idx = 2'd0;
      end else if (pick[1]) begin
        gnt     = 3'b010;
        gnt_idx = 2'd1;
      end else if (pick[2]) begin
        gnt     = 3'b100;
        gnt_idx = 2'd2;
      end
    end
    any_gnt   = (gnt != 3'b000);
    gnt_we    = we_i[gnt_idx];
    sel_addr  = addr_i[gnt_idx*AW +: AW];
    sel_wdata = wdata_i[gnt_idx*DW +: DW];
  end

  assign gnt_o   = gnt;
  assign rdata_o = data_i;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      CS_o         <= 1'b0;
      WR_o         <= 1'b0;
      data_tri_ena <= 1'b0;
      addr_o       <= '0;
      data_o       <= '0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 2'd0;
      rvalid_o     <= 3'b000;
      for (int p = 0; p < 3; p++) wait_q[p] <= '0;
    end else begin
      CS_o         <= any_gnt;
      WR_o         <= any_gnt & gnt_we;
      data_tri_ena <= any_gnt & gnt_we;
      // Address and write data hold across idle cycles to avoid pin toggling.
      if (any_gnt) begin
        addr_o <= sel_addr;
        data_o <= sel_wdata;
      end
      rd_pend_q <= any_gnt & ~gnt_we;
      rd_port_q <= gnt_idx;
      // Second pipeline stage: SRAM returns data now, flag the owning port.
      rvalid_o  <= rd_pend_q ? (3'b001 << rd_port_q) : 3'b000;
      for (int p = 0; p < 3; p++) begin
        if (!req_i[p] || gnt[p])
          wait_q[p] <= '0;
        else if (wait_q[p] != WAIT_MAX)
          wait_q[p] <= wait_q[p] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dtw_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_dtw_mem_arb
//   Self-checking bench for dtw_mem_arb. A behavioural SRAM drives data_i from
//   the registered pins. A reference model tracks per-port waiting time, the
//   turnaround rule, expected pin commands, its own copy of memory contents
//   and a queue of outstanding reads with their due cycles. Directed scenarios
//   are followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_dtw_mem_arb;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [2:0]      req_i;
  logic [2:0]      we_i;
  logic [3*AW-1:0] addr_i;
  logic [3*DW-1:0] wdata_i;
  logic [2:0]      gnt_o;
  logic [2:0]      rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   data_o;
  logic            data_tri_ena;
  logic            WR_o;
  logic            CS_o;
  logic [DW-1:0]   data_i = '0;

  // Per-port requester registers
  logic          p_req   [3];
  logic          p_we    [3];
  logic [AW-1:0] p_addr  [3];
  logic [DW-1:0] p_wdata [3];

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      req_i[p]               = p_req[p];
      we_i[p]                = p_we[p];
      addr_i[p*AW +: AW]     = p_addr[p];
      wdata_i[p*DW +: DW]    = p_wdata[p];
    end
  end

  always #5 clk_i = ~clk_i;

  dtw_mem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .addr_o(addr_o), .data_o(data_o),
    .data_tri_ena(data_tri_ena), .WR_o(WR_o), .CS_o(CS_o), .data_i(data_i)
  );

  // Behavioural SRAM on the pins
  logic [DW-1:0] sram [1024];
  always @(posedge clk_i) begin
    if (CS_o && WR_o)  sram[addr_o] <= data_o;
    if (CS_o && !WR_o) data_i <= sram[addr_o];
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Reference model state
  typedef struct {
    int            port;
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [1024];
  rd_t           rdq [$];
  int            wt [3];
  bit            prev_read;
  int            cyc;
  logic          exp_cs, exp_wr, exp_tri;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            last_g;

  // Observations captured at the sampling point of the latest step
  logic [2:0]    obs_gnt, obs_rvalid;
  logic [DW-1:0] obs_rdata;
  logic          obs_cs, obs_wr, obs_tri;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rdq.delete();
    for (int p = 0; p < 3; p++) wt[p] = 0;
    prev_read = 1'b0;
    exp_cs    = 1'b0;
    exp_wr    = 1'b0;
    exp_tri   = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // model across the rising edge. Inputs are changed by the caller afterwards.
  task automatic step();
    int            g;
    logic [2:0]    exp_rv;
    logic [DW-1:0] exp_rd;
    bit            elig [3];
    rd_t           r;
    @(negedge clk_i);
    obs_gnt    = gnt_o;
    obs_rvalid = rvalid_o;
    obs_rdata  = rdata_o;
    obs_cs     = CS_o;
    obs_wr     = WR_o;
    obs_tri    = data_tri_ena;
    obs_addr   = addr_o;
    obs_data   = data_o;

    check("cs", obs_cs, exp_cs);
    check("wr", obs_wr, exp_wr);
    check("tri_ena", obs_tri, exp_tri);
    check("addr_o", obs_addr, exp_addr);
    check("data_o", obs_data, exp_data);

    exp_rv = 3'b000;
    exp_rd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      exp_rv[r.port] = 1'b1;
      exp_rd = r.data;
    end
    check("rvalid", obs_rvalid, exp_rv);
    if (exp_rv != 3'b000) check("rdata", obs_rdata, exp_rd);

    g = -1;
    if (!rst_i) begin
      for (int p = 0; p < 3; p++) elig[p] = p_req[p] && !(p_we[p] && prev_read);
      for (int p = 0; p < 3; p++) if (g < 0 && elig[p] && wt[p] >= MAX_WAIT) g = p;
      for (int p = 0; p < 3; p++) if (g < 0 && elig[p]) g = p;
    end
    check("gnt", obs_gnt, (g < 0) ? 64'd0 : (64'd1 << g));
    last_g = g;

    @(posedge clk_i);
    cyc++;
    if (rst_i) begin
      model_reset();
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (!p_req[p] || g == p) wt[p] = 0;
        else if (wt[p] < MAX_WAIT) wt[p] = wt[p] + 1;
      end
      if (g >= 0) begin
        exp_cs   = 1'b1;
        exp_wr   = p_we[g];
        exp_tri  = p_we[g];
        exp_addr = p_addr[g];
        exp_data = p_wdata[g];
        if (p_we[g]) ref_mem[p_addr[g]] = p_wdata[g];
        else rdq.push_back('{port: g, due: cyc + 1, data: ref_mem[p_addr[g]]});
        prev_read = !p_we[g];
      end else begin
        exp_cs    = 1'b0;
        exp_wr    = 1'b0;
        exp_tri   = 1'b0;
        prev_read = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[p]   = r;
    p_we[p]    = w;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 3; p++) p_req[p] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_gnt [3];
    int cnt0;

    for (int i = 0; i < 1024; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    cyc = 0;
    model_reset();

    // Reset with every port requesting
    rst_i = 1'b1;
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, AW'(p), '0);
    repeat (2) @(posedge clk_i);
    #1;
    step();
    check("rst_gnt_forced_low", obs_gnt, 3'b000);
    rst_i = 1'b0;
    idle_all();
    step();
    check("rst_cs", obs_cs, 1'b0);
    check("rst_addr", obs_addr, '0);

    // Single read by port 1
    set_port(1, 1'b1, 1'b0, 10'h012, '0);
    step();
    check("rd_gnt", obs_gnt, 3'b010);
    idle_all();
    step();
    check("rd_cmd_cs", obs_cs, 1'b1);
    check("rd_cmd_addr", obs_addr, 10'h012);
    step();
    check("rd_rvalid", obs_rvalid, 3'b010);
    check("rd_rdata", obs_rdata, init_word(12'h012));

    // All three ports reading continuously
    for (int p = 0; p < 3; p++) begin
      set_port(p, 1'b1, 1'b0, AW'(10'h100 + p), '0);
      first_gnt[p] = -1;
    end
    cnt0 = 0;
    for (int t = 0; t < 12; t++) begin
      step();
      for (int p = 0; p < 3; p++) if (obs_gnt[p] && first_gnt[p] < 0) first_gnt[p] = t;
      if (t < 8 && obs_gnt[0]) cnt0++;
    end
    check("prio_p0_cycles_0_7", cnt0, 8);
    check("prio_p1_first", first_gnt[1], 8);
    check("prio_p2_by_9", (first_gnt[2] >= 0 && first_gnt[2] <= 9), 1'b1);
    idle_all();
    repeat (3) step();

    // Read followed by a pending write: one bubble
    set_port(1, 1'b1, 1'b0, 10'h020, '0);
    step();
    check("ta_read_gnt", obs_gnt, 3'b010);
    idle_all();
    set_port(0, 1'b1, 1'b1, 10'h021, 32'hA5A5_0001);
    step();
    check("ta_bubble", obs_gnt, 3'b000);
    step();
    check("ta_write_gnt", obs_gnt, 3'b001);
    check("ta_pin_idle", obs_cs, 1'b0);
    idle_all();
    step();
    check("ta_tri_ena", obs_tri, 1'b1);

    // Write then read of the same word, back to back
    set_port(0, 1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF);
    step();
    check("wr_gnt", obs_gnt, 3'b001);
    idle_all();
    set_port(2, 1'b1, 1'b0, 10'h3FF, '0);
    step();
    check("war_no_bubble", obs_gnt, 3'b100);
    idle_all();
    step();
    step();
    check("war_rvalid", obs_rvalid, 3'b100);
    check("war_rdata", obs_rdata, 32'hDEAD_BEEF);

    // Reset while a read is in flight
    set_port(1, 1'b1, 1'b0, 10'h055, '0);
    step();
    check("rr_gnt", obs_gnt, 3'b010);
    idle_all();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check("rr_no_rvalid", obs_rvalid, 3'b000);
    check("rr_cs", obs_cs, 1'b0);
    check("rr_addr", obs_addr, '0);
    check("rr_data", obs_data, '0);

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      for (int p = 0; p < 3; p++) begin
        if (last_g == p || !p_req[p]) begin
          p_req[p]   = ($urandom_range(0, 9) < 6);
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
          p_wdata[p] = $urandom;
        end
      end
      rst_i = ($urandom_range(0, 99) == 0);
      step();
    end
    rst_i = 1'b0;
    idle_all();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_mem_arb.md
# dtw_mem_arb

Single-port SRAM arbiter and sequencer for the DTW accelerator. It shares the one 1024x32 external SRAM port (template storage and backtrace result area) between three requesters: the backtrace writeback, the template fetch in the DTW controller, and a host/debug port. It grants one access per cycle using fixed priority plus aging. It also inserts bus-turnaround bubbles and returns read data with a fixed latency. It sits between the DTW control/backtrace blocks and the top-level SRAM pins.

## Interface
- AW, 10, SRAM address width
- DW, 32, SRAM data width
- MAX_WAIT, 8, wait-counter saturation value that makes a port urgent (must be >=1)
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  3  per-port request; [0]=BT writeback, [1]=template fetch, [2]=host
- we_i  in  3  per-port write enable (1=write, 0=read)
- addr_i  in  3*AW  per-port address, port p at [p*AW +: AW]
- wdata_i  in  3*DW  per-port write data, port p at [p*DW +: DW]
- gnt_o  out  3  per-port grant, one-hot or zero, combinational (Mealy)
- rvalid_o  out  3  per-port read-data-valid pulse, registered
- rdata_o  out  DW  shared read data, equals data_i
- addr_o  out  AW  SRAM address, registered
- data_o  out  DW  SRAM write data, registered
- data_tri_ena  out  1  pad drive enable for data_o, registered
- WR_o  out  1  SRAM write strobe (1=write), registered
- CS_o  out  1  SRAM chip select (1=access), registered
- data_i  in  DW  SRAM read data, valid the cycle after a read command

## Operation
- Requester protocol:
  - Hold req/we/addr/wdata stable until gnt is high at a rising edge.
  - At that edge the access is accepted.
  - The requester may drop req or present a new request for the next cycle.
- Eligibility: port p is eligible when req_i[p]=1, except a write (we_i[p]=1) is ineligible in the cycle directly after a read was granted (turnaround bubble). Read-after-write needs no gap.
- Aging: wait_p (width clog2(MAX_WAIT+1)):
  - +1 each cycle req_i[p]=1 and gnt_o[p]=0, saturating at MAX_WAIT.
  - Cleared to 0 on grant or when req_i[p]=0.
  - A port with wait_p==MAX_WAIT is urgent. It keeps aging state while blocked by turnaround.
- Selection among eligible ports:
  - The lowest-index urgent port wins.
  - If none is urgent, fixed priority applies: 0 > 1 > 2.
  - At most one grant per cycle.
- Command issue: on the grant edge, register the SRAM command: CS_o=1, WR_o=we, addr_o=addr, data_o=wdata, data_tri_ena=we.
- No grant in a cycle: CS_o=0, WR_o=0, data_tri_ena=0 next cycle. addr_o and data_o hold their previous values.
- Read return: a pending-read pipeline records the port index. rvalid_o[p] pulses for one cycle, during which rdata_o=data_i. Consecutive reads pipeline at one per cycle.
- Reset: synchronous rst_i clears all registers, in-flight reads (no rvalid is issued) and wait counters.
  - All outputs are 0 in the cycle after the reset edge; addr_o and data_o also reset to 0.
  - gnt_o is forced to 0 while rst_i=1.

## Timing
- Cycle c: gnt_o[p]=1 (same cycle as an eligible req).
- Cycle c+1: SRAM command on pins.
- Cycle c+2 (reads only): data_i valid, rvalid_o[p]=1, rdata_o valid.
- Throughput:
  - 1 access/cycle for read streams and write streams.
  - read->write costs 1 idle pin cycle.
  - write->read costs none.
- Worst-case grant wait for a continuously requesting port: bounded by MAX_WAIT plus 2 urgent predecessors plus 1 turnaround cycle.
- Simultaneous events:
  - A grant edge coinciding with a read return of another port is legal; both happen.
  - With rst_i=1, reset wins over everything.

## Test plan
- Reset: assert rst_i with req_i=3'b111 -> gnt_o=0 during reset; CS_o=WR_o=data_tri_ena=rvalid_o=0, addr_o=0 after the edge.
- Single read: port 1 reads addr 0x012 at cycle c -> gnt_o=3'b010 at c; CS_o=1, WR_o=0, addr_o=0x012 at c+1; rvalid_o=3'b010 with rdata_o=SRAM[0x012] at c+2.
- Priority: all three ports request reads continuously, MAX_WAIT=8 -> port 0 granted cycles 0-7; port 1 urgent and granted at cycle 8; port 2 granted no later than cycle 9.
- Turnaround: port 1 reads at c, port 0 write pending -> gnt_o=0 at c+1; write granted at c+2; pins show CS_o=0 at c+2 and data_tri_ena=1 at c+3.
- Write->read back-to-back: port 0 writes 0xDEADBEEF to 0x3FF at c, port 2 reads 0x3FF at c+1 -> no bubble; rvalid_o[2]=1 at c+3 with rdata_o=0xDEADBEEF (SRAM model).
- Reset mid-read: read granted at c, rst_i=1 at c+1 -> no rvalid_o pulse at c+2; all outputs 0.
